nx1_mem_arb: RTL and testbench

Three-port memory arbiter with an integrated refresh scheduler, sitting between the NX1 core's memory requesters (video fetch, CPU, FDD/DMA) and the single-port SDRAM command sequencer that drives the DE0 DRAM pins. It grants one requester at a time, latches its command, forwards it downstream, and returns the read data with a one-cycle acknowledge. It also generates periodic refresh requests that pre-empt all other traffic at the next idle point.

---
 rtl/nx1_mem_pkg.sv | 17 +
 rtl/nx1_ref_timer.sv | 51 +++++
 rtl/nx1_mem_arb.sv | 177 +++++++++++++++++
 tb/tb_nx1_mem_arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx1_mem_pkg.sv
// Shared definitions for the NX1 three-port memory arbiter.
package nx1_mem_pkg;

  localparam int NX1_DEF_AW = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_REF  = 2'd2,
    ST_ACK  = 2'd3
  } arb_state_t;

  localparam logic [1:0] PORT_VIDEO = 2'd0;
  localparam logic [1:0] PORT_CPU   = 2'd1;
  localparam logic [1:0] PORT_FDD   = 2'd2;

endpackage

// File: rtl/nx1_ref_timer.sv
// Refresh interval timer: queues one refresh per interval, flags an overrun
// when an interval expires while the previous refresh is still outstanding.
module nx1_ref_timer
  import nx1_mem_pkg::*;
#(
  parameter int def_REF_INTERVAL = 390
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic ref_done,
  output logic ref_pend,
  output logic ref_ovf
);

  localparam logic [15:0] RELOAD = 16'(def_REF_INTERVAL - 1);

  logic [15:0] cnt_reg, cnt_next;
  logic        pend_reg, pend_next;
  logic        ovf_reg, ovf_next;
  logic        expire;

  always_comb begin
    expire    = (cnt_reg == 16'd0);
    cnt_next  = expire ? RELOAD : cnt_reg - 16'd1;
    pend_next = pend_reg;
    ovf_next  = ovf_reg;
    // A refresh completing on the expiry edge leaves the new one queued, not an overrun
    if (expire) begin
      if (pend_reg && !ref_done) ovf_next = 1'b1;
      pend_next = 1'b1;
    end else if (ref_done) begin
      pend_next = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_reg  <= RELOAD;
      pend_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      pend_reg <= pend_next;
      ovf_reg  <= ovf_next;
    end
  end

  assign ref_pend = pend_reg;
  assign ref_ovf  = ovf_reg;

endmodule

// File: rtl/nx1_mem_arb.sv
// Three-port SDRAM arbiter (video fixed priority, CPU/FDD round-robin) with
// refresh pre-emption at the next idle point.
module nx1_mem_arb
  import nx1_mem_pkg::*;
#(
  parameter int def_AW           = NX1_DEF_AW,
  parameter int def_REF_INTERVAL = 390
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              p0_req,
  input  logic [def_AW-1:0] p0_addr,
  input  logic              p0_we,
  input  logic [15:0]       p0_wdata,
  input  logic [1:0]        p0_be,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic [def_AW-1:0] p1_addr,
  input  logic              p1_we,
  input  logic [15:0]       p1_wdata,
  input  logic [1:0]        p1_be,
  output logic              p1_ack,
  input  logic              p2_req,
  input  logic [def_AW-1:0] p2_addr,
  input  logic              p2_we,
  input  logic [15:0]       p2_wdata,
  input  logic [1:0]        p2_be,
  output logic              p2_ack,
  output logic [15:0]       rdata,
  output logic              mem_req,
  output logic [def_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              ref_req,
  input  logic              ref_ack,
  output logic              ref_ovf
);

  arb_state_t        state_reg, state_next;
  logic [1:0]        grant_reg, grant_next;
  logic              rr_fdd_reg, rr_fdd_next;   // 1: port 2 wins a CPU/FDD tie
  logic              mem_req_reg, mem_req_next;
  logic [def_AW-1:0] mem_addr_reg, mem_addr_next;
  logic              mem_we_reg, mem_we_next;
  logic [15:0]       mem_wdata_reg, mem_wdata_next;
  logic [1:0]        mem_be_reg, mem_be_next;
  logic [15:0]       rdata_reg, rdata_next;
  logic [2:0]        ack_reg, ack_next;
  logic              ref_req_reg, ref_req_next;

  logic              ref_pend, ref_done;
  logic              grant_hit;
  logic [1:0]        grant_sel;

  nx1_ref_timer #(.def_REF_INTERVAL(def_REF_INTERVAL)) u_ref_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ref_done (ref_done),
    .ref_pend (ref_pend),
    .ref_ovf  (ref_ovf)
  );

  always_comb begin
    grant_hit = 1'b1;
    grant_sel = PORT_VIDEO;
    if (p0_req)                          grant_sel = PORT_VIDEO;
    else if (p1_req && !(p2_req && rr_fdd_reg)) grant_sel = PORT_CPU;
    else if (p2_req)                     grant_sel = PORT_FDD;
    else                                 grant_hit = 1'b0;
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_fdd_next    = rr_fdd_reg;
    mem_req_next   = mem_req_reg;
    mem_addr_next  = mem_addr_reg;
    mem_we_next    = mem_we_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_be_next    = mem_be_reg;
    rdata_next     = rdata_reg;
    ack_next       = 3'b000;
    ref_req_next   = ref_req_reg;
    ref_done       = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (ref_pend) begin
          ref_req_next = 1'b1;
          state_next   = ST_REF;
        end else if (grant_hit) begin
          grant_next   = grant_sel;
          mem_req_next = 1'b1;
          state_next   = ST_ACC;
          unique case (grant_sel)
            PORT_CPU: begin
              mem_addr_next = p1_addr; mem_we_next = p1_we;
              mem_wdata_next = p1_wdata; mem_be_next = p1_be;
            end
            PORT_FDD: begin
              mem_addr_next = p2_addr; mem_we_next = p2_we;
              mem_wdata_next = p2_wdata; mem_be_next = p2_be;
            end
            default: begin
              mem_addr_next = p0_addr; mem_we_next = p0_we;
              mem_wdata_next = p0_wdata; mem_be_next = p0_be;
            end
          endcase
        end
      end
      ST_ACC: begin
        if (mem_ack) begin
          mem_req_next = 1'b0;
          rdata_next   = mem_rdata;
          ack_next     = 3'b001 << grant_reg;
          state_next   = ST_ACK;
        end
      end
      ST_ACK: begin
        // Requests are not sampled here so a port dropping req on its ack is not re-served
        if (grant_reg == PORT_CPU)      rr_fdd_next = 1'b1;
        else if (grant_reg == PORT_FDD) rr_fdd_next = 1'b0;
        state_next = ST_IDLE;
      end
      ST_REF: begin
        if (ref_ack) begin
          ref_req_next = 1'b0;
          ref_done     = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= PORT_VIDEO;
      rr_fdd_reg    <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_we_reg    <= 1'b0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      rdata_reg     <= '0;
      ack_reg       <= '0;
      ref_req_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_fdd_reg    <= rr_fdd_next;
      mem_req_reg   <= mem_req_next;
      mem_addr_reg  <= mem_addr_next;
      mem_we_reg    <= mem_we_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_be_reg    <= mem_be_next;
      rdata_reg     <= rdata_next;
      ack_reg       <= ack_next;
      ref_req_reg   <= ref_req_next;
    end
  end

  assign p0_ack    = ack_reg[0];
  assign p1_ack    = ack_reg[1];
  assign p2_ack    = ack_reg[2];
  assign rdata     = rdata_reg;
  assign mem_req   = mem_req_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_we    = mem_we_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_be    = mem_be_reg;
  assign ref_req   = ref_req_reg;

endmodule

// File: tb/tb_nx1_mem_arb.sv
// Bench for nx1_mem_arb: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_nx1_mem_arb;
  localparam int AW = 22;
  localparam int RI = 16;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [2:0]    req = '0;
  logic [AW-1:0] addr [3];
  logic          we [3];
  logic [15:0]   wdata [3];
  logic [1:0]    be [3];
  logic ack0, ack1, ack2;
  logic [2:0] ack;
  logic [15:0] rdata;
  logic mem_req, mem_we, ref_req, ref_ovf;
  logic [AW-1:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0] mem_be;
  logic mem_ack = 1'b0, ref_ack = 1'b0;
  logic [15:0] mem_rdata = '0;

  assign ack = {ack2, ack1, ack0};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  nx1_mem_arb #(.def_AW(AW), .def_REF_INTERVAL(RI)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .p0_req(req[0]), .p0_addr(addr[0]), .p0_we(we[0]), .p0_wdata(wdata[0]), .p0_be(be[0]), .p0_ack(ack0),
    .p1_req(req[1]), .p1_addr(addr[1]), .p1_we(we[1]), .p1_wdata(wdata[1]), .p1_be(be[1]), .p1_ack(ack1),
    .p2_req(req[2]), .p2_addr(addr[2]), .p2_we(we[2]), .p2_wdata(wdata[2]), .p2_be(be[2]), .p2_ack(ack2),
    .rdata(rdata), .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ref_req(ref_req), .ref_ack(ref_ack), .ref_ovf(ref_ovf)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- sequencer / refresh responder ----------------
  int mem_dly_min = 0, mem_dly_max = 0, ref_dly_min = 0, ref_dly_max = 0;
  bit ref_hold = 0, spurious = 0, fix_rdata_en = 0;
  logic [15:0] fix_rdata = '0;
  int  mem_cnt = 0, mem_target = 0, ref_cnt = 0, ref_target = 0;
  bit  mem_busy = 0, ref_busy = 0;

  always @(negedge CLK) begin
    mem_ack = 1'b0;
    ref_ack = 1'b0;
    if (mem_req) begin
      if (!mem_busy) begin
        mem_busy = 1; mem_cnt = 0;
        mem_target = $urandom_range(mem_dly_max, mem_dly_min);
      end
      if (mem_cnt >= mem_target) begin
        mem_ack = 1'b1; mem_busy = 0;
        mem_rdata = fix_rdata_en ? fix_rdata : 16'($urandom);
      end else mem_cnt++;
    end else begin
      mem_busy = 0;
      mem_rdata = 16'($urandom);
      if (spurious && $urandom_range(7, 0) == 0) mem_ack = 1'b1;
    end
    if (ref_req && !ref_hold) begin
      if (!ref_busy) begin
        ref_busy = 1; ref_cnt = 0;
        ref_target = $urandom_range(ref_dly_max, ref_dly_min);
      end
      if (ref_cnt >= ref_target) begin ref_ack = 1'b1; ref_busy = 0; end
      else ref_cnt++;
    end else if (!ref_req) begin
      ref_busy = 0;
      if (spurious && $urandom_range(7, 0) == 0) ref_ack = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  // Arbiter phase is inferred from the outputs themselves: a latched access is
  // outstanding, a refresh is outstanding, an ack is showing, or it is idle.
  logic [2:0]    e_ack = '0;
  logic [15:0]   e_rdata = '0, e_wdata = '0;
  logic          e_mem_req = 0, e_we = 0, e_ref_req = 0, e_ovf = 0;
  logic [AW-1:0] e_addr = '0;
  logic [1:0]    e_be = '0;
  bit m_pend = 0;
  int m_last = 2;     // port 1 wins the first CPU/FDD tie
  int m_port = 0;
  int m_cyc  = 0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      e_ack = '0; e_rdata = '0; e_mem_req = 0; e_addr = '0; e_we = 0;
      e_wdata = '0; e_be = '0; e_ref_req = 0; e_ovf = 0;
      m_pend = 0; m_last = 2; m_port = 0; m_cyc = 0;
    end else begin
      bit idle, done, expire;
      int w;
      idle = !e_mem_req && !e_ref_req && (e_ack == 3'b000);
      done = e_ref_req && ref_ack;
      m_cyc++;
      expire = (m_cyc % RI) == 0;
      if (req[0]) w = 0;
      else if (req[1] && req[2]) w = (m_last == 1) ? 2 : 1;
      else if (req[1]) w = 1;
      else if (req[2]) w = 2;
      else w = -1;
      if (e_ack != 3'b000) begin
        e_ack = '0;
        if (m_port != 0) m_last = m_port;
      end else if (e_mem_req && mem_ack) begin
        e_mem_req = 0; e_rdata = mem_rdata; e_ack = 3'b001 << m_port;
      end else if (done) begin
        e_ref_req = 0;
      end else if (idle) begin
        if (m_pend) e_ref_req = 1;
        else if (w >= 0) begin
          m_port = w; e_mem_req = 1;
          e_addr = addr[w]; e_we = we[w]; e_wdata = wdata[w]; e_be = be[w];
        end
      end
      if (expire) begin
        if (m_pend && !done) e_ovf = 1;
        m_pend = 1;
      end else if (done) m_pend = 0;
    end
  end

  always @(negedge CLK) begin
    check("cmp_ack",       32'(ack),       32'(e_ack));
    check("cmp_rdata",     32'(rdata),     32'(e_rdata));
    check("cmp_mem_req",   32'(mem_req),   32'(e_mem_req));
    check("cmp_mem_addr",  32'(mem_addr),  32'(e_addr));
    check("cmp_mem_we",    32'(mem_we),    32'(e_we));
    check("cmp_mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    check("cmp_mem_be",    32'(mem_be),    32'(e_be));
    check("cmp_ref_req",   32'(ref_req),   32'(e_ref_req));
    check("cmp_ref_ovf",   32'(ref_ovf),   32'(e_ovf));
    if (ack != 3'b000) $display("[TB] txn ack=%b rdata=%h t=%0t", ack, rdata, $time);
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    @(negedge CLK); #2 RST_N = 1'b0;
    @(negedge CLK); @(negedge CLK); RST_N = 1'b1;
  endtask

  task automatic wait_ack(input int lim, input bit drop, input int exp_port, input string nm);
    int port;
    port = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge CLK);
      if (ack != 3'b000) begin
        for (int p = 0; p < 3; p++) if (ack[p]) port = p;
        if (drop) req[port] = 1'b0;
        break;
      end
    end
    check(nm, 32'(port), 32'(exp_port));
  endtask

  task automatic wait_mem_req(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge CLK);
      if (mem_req) break;
    end
    check("mem_req_rise", 32'(mem_req), 32'(1));
  endtask

  initial begin
    int first_ref, second_ref, ovf_at, hold_cnt, ack_cnt;
    bit prev;
    for (int p = 0; p < 3; p++) begin
      addr[p] = '0; we[p] = 0; wdata[p] = '0; be[p] = '0;
    end
    repeat (3) @(negedge CLK);
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_ack",     32'(ack),     32'(0));
    check("rst_rdata",   32'(rdata),   32'(0));
    check("rst_ref_req", 32'(ref_req), 32'(0));
    RST_N = 1'b1;

    // refresh cadence and overrun with idle ports
    first_ref = -1; second_ref = -1; ovf_at = -1; prev = 0;
    for (int c = 1; c <= 90; c++) begin
      @(negedge CLK);
      if (c == 40) ref_hold = 1;
      if (c == 70) ref_hold = 0;
      if (ref_req && !prev) begin
        if (first_ref < 0) first_ref = c;
        else if (second_ref < 0) second_ref = c;
      end
      if (ref_ovf && ovf_at < 0) ovf_at = c;
      prev = ref_req;
    end
    check("ref_first_rise",  32'(first_ref),  32'(17));
    check("ref_second_rise", 32'(second_ref), 32'(33));
    check("ref_ovf_cycle",   32'(ovf_at),     32'(64));
    check("ref_ovf_sticky",  32'(ref_ovf),    32'(1));

    // p0 request arriving as a refresh becomes pending: refresh first
    do_reset();
    check("rst_ovf_clear", 32'(ref_ovf), 32'(0));
    repeat (16) @(negedge CLK);
    req[0] = 1; addr[0] = 22'h00ABC; we[0] = 0;
    @(negedge CLK);
    check("p0ref_ref_first", 32'(ref_req), 32'(1));
    check("p0ref_no_access", 32'(mem_req), 32'(0));
    wait_ack(40, 1, 0, "p0ref_ack_port");

    // CPU/FDD alternation, then video pre-emption
    mem_dly_min = 0; mem_dly_max = 1;
    req[1] = 1; addr[1] = 22'h011111; req[2] = 1; addr[2] = 22'h022222;
    wait_ack(40, 0, 1, "rr_ack_1");
    wait_ack(40, 0, 2, "rr_ack_2");
    wait_ack(40, 0, 1, "rr_ack_3");
    wait_ack(40, 0, 2, "rr_ack_4");
    req[0] = 1; addr[0] = 22'h000777;
    wait_ack(40, 1, 0, "rr_p0_preempt");
    req = '0;

    // single read on port 1
    repeat (3) @(negedge CLK);
    mem_dly_min = 2; mem_dly_max = 2; fix_rdata_en = 1; fix_rdata = 16'hBEEF;
    req[1] = 1; addr[1] = 22'h012345; we[1] = 0; be[1] = 2'b11;
    wait_mem_req(40);
    check("rd_mem_addr", 32'(mem_addr), 32'h12345);
    check("rd_mem_we",   32'(mem_we),   32'(0));
    wait_ack(40, 1, 1, "rd_ack_port");
    check("rd_rdata", 32'(rdata), 32'hBEEF);
    @(negedge CLK);
    check("rd_ack_once", 32'(ack), 32'(0));
    fix_rdata_en = 0;

    // write on port 2 held through a slow sequencer
    mem_dly_min = 5; mem_dly_max = 5;
    req[2] = 1; addr[2] = 22'h30F0F0; we[2] = 1; be[2] = 2'b01; wdata[2] = 16'hA55A;
    wait_mem_req(40);
    addr[2] = '0; wdata[2] = 16'h0000; be[2] = 2'b10;
    hold_cnt = 0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      check("wr_mem_addr",  32'(mem_addr),  32'h30F0F0);
      check("wr_mem_we",    32'(mem_we),    32'(1));
      check("wr_mem_be",    32'(mem_be),    32'(2'b01));
      check("wr_mem_wdata", 32'(mem_wdata), 32'hA55A);
      hold_cnt++;
      @(negedge CLK);
    end
    check("wr_hold_cycles", 32'(hold_cnt), 32'(6));
    check("wr_ack", 32'(ack), 32'(3'b100));
    req[2] = 0;

    // reset while an access is outstanding
    mem_dly_min = 10; mem_dly_max = 10;
    req[1] = 1; addr[1] = 22'h2AAAA; we[1] = 0;
    wait_mem_req(40);
    @(negedge CLK);
    #2 RST_N = 1'b0; req[1] = 0;
    #1;
    check("acc_rst_mem_req",  32'(mem_req),  32'(0));
    check("acc_rst_mem_addr", 32'(mem_addr), 32'(0));
    check("acc_rst_ack",      32'(ack),      32'(0));
    check("acc_rst_rdata",    32'(rdata),    32'(0));
    @(negedge CLK); @(negedge CLK); RST_N = 1'b1;
    ack_cnt = 0;
    repeat (12) begin
      @(negedge CLK);
      if (ack != 3'b000) ack_cnt++;
    end
    check("acc_rst_no_ack", 32'(ack_cnt), 32'(0));

    // random traffic
    mem_dly_min = 0; mem_dly_max = 4; ref_dly_min = 0; ref_dly_max = 3; spurious = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if (c == 1500) ref_hold = 1;
      if (c == 1540) ref_hold = 0;
      if (c == 2200) #2 RST_N = 1'b0;
      if (c == 2202) RST_N = 1'b1;
      for (int p = 0; p < 3; p++) begin
        if (ack[p]) req[p] = 0;
        else if (!req[p]) begin
          if ($urandom_range((p == 0) ? 9 : 3, 0) == 0) begin
            req[p] = 1; addr[p] = AW'($urandom); we[p] = 1'($urandom);
            wdata[p] = 16'($urandom); be[p] = 2'($urandom);
          end
        end else if ($urandom_range(7, 0) == 0) begin
          addr[p] = AW'($urandom); wdata[p] = 16'($urandom);
        end
      end
    end
    req = '0;
    repeat (20) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
